// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU and their W variants (one quotient bit per cycle).
// DIV_ZERO_FASTPATH_EN: divide-by-zero and signed overflow skip the iteration and finish one cycle after accept.
module div_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             word,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic [1:0] op;
    logic       word;
    logic       dz;
    logic       ovf;
    logic       neg_q;
    logic       neg_r;
  } ctx_t;

  state_t           state, state_nxt;
  ctx_t             ctx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo, rem, dvs, a_r;

  logic             sgn, sa, sb, dz_in, ovf_in, accept, borrow;
  logic [WIDTH-1:0] abs_a, abs_b, sel, val, res;
  logic [WIDTH:0]   rem_sh, diff;

  assign sgn    = ~op[0];
  assign sa     = sgn & a[WIDTH-1];
  assign sb     = sgn & b[WIDTH-1];
  assign abs_a  = sa ? -a : a;
  assign abs_b  = sb ? -b : b;
  assign dz_in  = (b == '0);
  // W ops overflow on the 32-bit most-negative value; operands arrive sign-extended
  assign ovf_in = sgn & (word ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                              : (a == MINV && b == '1));
  assign accept = (state == IDLE) & in_valid & ~flush;

  assign rem_sh = {rem, quo[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs};
  assign borrow = diff[WIDTH];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
        state_nxt = BUSY;
`ifdef DIV_ZERO_FASTPATH_EN
        if (dz_in || ovf_in) state_nxt = DONE;
`endif
      end
      BUSY: if (cnt == CW'(WIDTH-1)) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctx <= '0;
      cnt <= '0;
      quo <= '0;
      rem <= '0;
      dvs <= '0;
      a_r <= '0;
    end else if (accept) begin
      ctx <= '{op: op, word: word, dz: dz_in, ovf: ovf_in, neg_q: sa ^ sb, neg_r: sa};
      cnt <= '0;
      quo <= abs_a;
      rem <= '0;
      dvs <= abs_b;
      a_r <= a;
    end else if (state == BUSY && !flush) begin
      cnt <= cnt + CW'(1);
      rem <= borrow ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      quo <= {quo[WIDTH-2:0], ~borrow};
    end
  end

  // Special cases override the iterated value so both build options agree
  always_comb begin
    sel = ctx.op[1] ? rem : quo;
    val = (~ctx.op[0] & (ctx.op[1] ? ctx.neg_r : ctx.neg_q)) ? -sel : sel;
    if (ctx.dz)       val = ctx.op[1] ? a_r : '1;
    else if (ctx.ovf) val = ctx.op[1] ? '0 : a_r;
    res = val;
    if (ctx.word) res = {{(WIDTH-32){val[31]}}, val[31:0]};
  end

  assign in_ready  = (state == IDLE) & ~reset;
  assign out_valid = (state == DONE);
  assign result    = (state == DONE) ? res : '0;

endmodule

// File: tb/tb_div_unit.sv
// Directed scoreboard bench for div_unit (WIDTH=64), latency and handshake checks included.
module tb_div_unit;
  localparam int W = 64;
`ifdef DIV_ZERO_FASTPATH_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = W + 1;
`endif
  localparam int NLAT = W + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0, in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic [1:0]   op = 2'b00;
  logic         word = 1'b0, flush = 1'b0;
  logic         out_valid, out_ready = 1'b1;
  logic [W-1:0] result;

  int checks = 0, failures = 0;
  logic [W-1:0] exp_q[$];

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .word(word), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request at the negedge; returns cycles from accept edge to out_valid
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [1:0] top,
                       input logic tw, input logic [W-1:0] exp, output int lat);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
    in_valid = 1'b1; a = ta; b = tb; op = top; word = tw;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; op = 2'($urandom); word = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic [1:0] top, input logic tw, input logic [W-1:0] exp,
                       input int exp_lat);
    int lat;
    logic [W-1:0] e;
    issue(ta, tb, top, tw, exp, lat);
    chk({tag, "_valid"}, W'(out_valid), W'(1));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    chk(tag, result, e);
    if (exp_lat > 0) chk({tag, "_lat"}, W'(lat), W'(exp_lat));
    @(posedge clk); #1;
    chk({tag, "_rdy"}, W'(in_ready), W'(1));
  endtask

  initial begin
    int lat;
    logic rose;
    logic [W-1:0] held;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", W'(in_ready), W'(0));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_result", result, '0);
    @(negedge clk); reset = 1'b0;
    #1 chk("post_rst_ready", W'(in_ready), W'(1));

    // signed / unsigned main function
    do_op("div_m7_2",   -64'sd7, 64'd2, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, NLAT);
    do_op("rem_m7_2",   -64'sd7, 64'd2, 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, NLAT);
    do_op("div_100_m7", 64'd100, -64'sd7, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF2, NLAT);
    do_op("rem_100_m7", 64'd100, -64'sd7, 2'b10, 1'b0, 64'd2, 0);
    do_op("rem_m100_7", -64'sd100, 64'd7, 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    do_op("divu_big",   64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 2'b01, 1'b0, 64'h5555_5555_5555_5555, NLAT);

    // divide by zero
    do_op("divu_z",  64'h10, 64'd0, 2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, ZLAT);
    do_op("remu_z",  64'h10, 64'd0, 2'b11, 1'b0, 64'h10, ZLAT);
    do_op("div_z",   -64'sd5, 64'd0, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, ZLAT);
    do_op("rem_z",   -64'sd5, 64'd0, 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, ZLAT);

    // signed overflow, 64-bit and W
    do_op("div_ovf", 64'h8000_0000_0000_0000, '1, 2'b00, 1'b0, 64'h8000_0000_0000_0000, ZLAT);
    do_op("rem_ovf", 64'h8000_0000_0000_0000, '1, 2'b10, 1'b0, 64'd0, ZLAT);
    do_op("divw_ovf", 64'hFFFF_FFFF_8000_0000, '1, 2'b00, 1'b1, 64'hFFFF_FFFF_8000_0000, 0);
    do_op("remw_ovf", 64'hFFFF_FFFF_8000_0000, '1, 2'b10, 1'b1, 64'd0, 0);

    // W sign extension of result bit 31
    do_op("divuw_ext", 64'h0000_0000_FFFF_FFFF, 64'd1, 2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, NLAT);
    do_op("remuw",     64'h0000_0000_FFFF_FFFF, 64'h10, 2'b11, 1'b1, 64'hF, NLAT);

    // backpressure in DONE
    out_ready = 1'b0;
    issue(64'd100, 64'd7, 2'b01, 1'b0, 64'd14, lat);
    chk("bp_lat", W'(lat), W'(NLAT));
    held = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    chk("bp_result", result, held);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", W'(out_valid), W'(1));
      chk("bp_hold_result", result, held);
      chk("bp_hold_ready", W'(in_ready), W'(0));
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", W'(in_ready), W'(1));
    chk("bp_release_valid", W'(out_valid), W'(0));

    // flush at BUSY cycle 30 with a competing request
    @(negedge clk);
    in_valid = 1'b1; a = 64'd1000; b = 64'd3; op = 2'b01; word = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (29) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; a = 64'd9; b = 64'd3;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle", W'(in_ready), W'(1));
    rose = out_valid;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      rose = rose | out_valid;
    end
    chk("flush_no_valid", W'(rose), W'(0));

    // async reset mid-BUSY
    @(negedge clk);
    in_valid = 1'b1; a = 64'd5; b = 64'd1; op = 2'b01; word = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_valid", W'(out_valid), W'(0));
    chk("arst_ready", W'(in_ready), W'(0));
    chk("arst_result", result, '0);
    @(negedge clk); reset = 1'b0;
    do_op("divu_after_rst", 64'd100, 64'd7, 2'b01, 1'b0, 64'd14, NLAT);

    chk("sb_empty", W'(exp_q.size()), W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning operand and result width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  request valid from decode.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request.
REQ-006 SHALL have port a  input  WIDTH  dividend; decode has already sign- or zero-extended it for W ops.
REQ-007 SHALL have port b  input  WIDTH  divisor; decode has already sign- or zero-extended it for W ops.
REQ-008 SHALL have port op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-009 SHALL have port word  input  1  W variant; the result is sign-extended from bit 31.
REQ-010 SHALL have port flush  input  1  kill any in-flight operation.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer takes the result.
REQ-013 SHALL have port result  output  WIDTH  quotient or remainder.

Function
REQ-014 SHALL implement the FSM states IDLE, BUSY and DONE; in_ready is 1 only in IDLE.
REQ-015 SHALL accept a request when in_valid and in_ready are both 1 and flush is 0.
- On accept: latch op and word; latch |a| and |b| for signed ops, or the raw values for unsigned ops.
- Record the quotient sign (a sign XOR b sign) and the remainder sign (a sign); go to BUSY with the iteration counter at 0.
REQ-016 SHALL, in BUSY, perform one restoring shift-subtract step per cycle, taking exactly WIDTH cycles, then go to DONE.
REQ-017 SHALL assert out_valid exactly WIDTH+1 cycles after the accept edge, in DONE.
- result = quotient for op[1]=0, remainder for op[1]=1, negated when the recorded sign is set (signed ops only).
REQ-018 SHALL produce result = all ones (quotient) or a (remainder) when the divisor is zero.
REQ-019 SHALL produce result = a (quotient) and 0 (remainder) for signed overflow (a = most negative, b = -1); no trap.
REQ-020 SHALL, when word=1, drive result[WIDTH-1:32] = result[31].
REQ-021 SHALL hold out_valid and result stable in DONE until out_ready=1, then return to IDLE on the next edge.
- in_ready rises in that IDLE cycle; no accept occurs in the DONE-exit cycle.
REQ-022 SHALL, on flush=1 in any state, go to IDLE on the next edge with out_valid=0.
- flush takes priority over in_valid and out_ready in the same cycle.
- A flushed result is never presented.
REQ-023 SHALL ignore a, b, op and word outside the accept cycle.

Reset
REQ-024 SHALL, while reset=1, force the state to IDLE, the counter and datapath registers to 0, out_valid=0, result=0, and in_ready=0.
- in_ready is 1 in the first cycle after reset deasserts.
REQ-025 SHALL abandon any BUSY or DONE operation on reset, with no result emitted.

Configuration
REQ-026 SHALL support macro DIV_ZERO_FASTPATH_EN.
- When defined: a request with b=0, or with signed overflow, goes directly from IDLE to DONE, with out_valid 1 cycle after accept and the result per REQ-018/REQ-019.
- When undefined: these cases take the full WIDTH+1 cycles and produce the same values.

Verification
REQ-027 SHALL cover DIV a=-7, b=2, word=0: result=0xFFFFFFFFFFFFFFFD with out_valid at cycle 65 after accept; REM gives 0xFFFFFFFFFFFFFFFF.
REQ-028 SHALL cover DIVU a=0x10, b=0: result=0xFFFFFFFFFFFFFFFF; REMU gives 0x10.
- Latency is 1 cycle with DIV_ZERO_FASTPATH_EN and 65 cycles without it.
REQ-029 SHALL cover DIV word=1, a=0xFFFFFFFF80000000, b=0xFFFFFFFFFFFFFFFF: result=0xFFFFFFFF80000000; REM gives 0.
REQ-030 SHALL cover out_ready=0 for 10 cycles in DONE: out_valid and result are held, in_ready=0; with out_ready=1, in_ready=1 on the next cycle.
REQ-031 SHALL cover flush asserted at BUSY cycle 30 with in_valid=1 in the same cycle: no accept, IDLE next cycle, and out_valid never rises.
REQ-032 SHALL cover reset asserted asynchronously mid-BUSY: out_valid=0 immediately, and a fresh DIVU 100/7 afterwards returns 14.
